// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg
//   Shared types and helpers for the word_serializer slice.
//   - state_t     : serializer FSM state (IDLE / BUSY)
//   - idx_width() : bit width of a word index for an N-word vector (min 1)
package word_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // An index register always needs at least one bit, even for N == 1.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if
//   Groups the vector input handshake and the word output stream.
//   Parameters: WIDTH (bits per word), N (words per vector).
//   Signals:
//     in_valid / in_ready / in   : packed N*WIDTH vector handshake
//     out_valid / out_ready / out: WIDTH-bit word stream
//     out_last                   : last word flag (WORD_SERIALIZER_LAST_EN only)
//   Modports: slave (the serializer), master (producer/consumer side).
interface word_serializer_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out;
`ifdef WORD_SERIALIZER_LAST_EN
  logic                 out_last;
`endif

  modport slave (
    input  in_valid, in, out_ready,
`ifdef WORD_SERIALIZER_LAST_EN
    output out_last,
`endif
    output in_ready, out_valid, out
  );

  modport master (
    output in_valid, in, out_ready,
`ifdef WORD_SERIALIZER_LAST_EN
    input  out_last,
`endif
    input  in_ready, out_valid, out
  );

endinterface

// File: rtl/word_serializer_wrap_counter.sv
// wrap_counter
//   Modulo-MAX index register: counts 0..MAX-1 and wraps back to 0.
//   Ports: clk, reset (sync, active-high), clear (forces 0, beats inc),
//          inc (advance by one), value (current count).
module wrap_counter
  import word_serializer_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        inc,
  output logic [idx_width(MAX)-1:0]   value
);

  localparam int CW = idx_width(MAX);
  localparam logic [CW-1:0] LAST_VAL = CW'(MAX - 1);

  // Index register with wrap at MAX-1; clear has priority over inc.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= {CW{1'b0}};
    end else if (clear) begin
      value <= {CW{1'b0}};
    end else if (inc) begin
      if (value == LAST_VAL) begin
        value <= {CW{1'b0}};
      end else begin
        value <= value + CW'(1);
      end
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// word_serializer
//   Parallel-to-serial converter: takes an N-word packed vector in one
//   handshake and emits the words one per transfer, element 0 first.
//   Parameters: WIDTH (bits per word), N (words per vector, >= 1).
//   Ports: clk, reset (sync, active-high), bus (word_serializer_if.slave).
//   Optional macro WORD_SERIALIZER_LAST_EN adds bus.out_last.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic              clk,
  input  logic              reset,
  word_serializer_if.slave  bus
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] buf_r [N];
  logic [IW-1:0]    idx_s;
  logic             is_last_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             out_valid_s;
  logic             idx_clear_s;
  logic             idx_inc_s;

  assign is_last_s   = (idx_s == LAST_IDX);
  assign out_valid_s = (state_r == BUSY);
  // Accepting while BUSY is only safe when the last word leaves this cycle.
  assign in_ready_s  = (state_r == IDLE) |
                       ((state_r == BUSY) & is_last_s & bus.out_ready);
  assign in_fire_s   = bus.in_valid & in_ready_s;
  assign out_fire_s  = out_valid_s & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out       = buf_r[idx_s];
`ifdef WORD_SERIALIZER_LAST_EN
  assign bus.out_last  = out_valid_s & is_last_s;
`endif

  // Word index; restarts on every accepted vector, wraps after the last word.
  wrap_counter #(
    .MAX (N)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clear (idx_clear_s),
    .inc   (idx_inc_s),
    .value (idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and index control.
  always_comb begin
    next_state_s = state_r;
    idx_clear_s  = 1'b0;
    idx_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_fire_s) begin
          next_state_s = BUSY;
          idx_clear_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        idx_inc_s   = out_fire_s;
        idx_clear_s = in_fire_s;
        if (out_fire_s && is_last_s && !bus.in_valid) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BUSY;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Vector buffer; loads only on an accepted input transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= {WIDTH{1'b0}};
      end
    end else if (in_fire_s) begin
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= bus.in[k*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= buf_r[k];
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
//   Directed self-checking bench for word_serializer: an N=4/WIDTH=8
//   instance and an N=1/WIDTH=16 instance sharing clock and reset.
module tb_word_serializer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  word_serializer_if #(.WIDTH(8),  .N(4)) bus4 ();
  word_serializer_if #(.WIDTH(16), .N(1)) bus1 ();

  word_serializer #(.WIDTH(8), .N(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  word_serializer #(.WIDTH(16), .N(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word4(input string tag, input logic [7:0] w, input logic last);
    check({tag, "_valid"}, 64'(bus4.out_valid), 64'd1);
    check({tag, "_out"}, 64'(bus4.out), 64'(w));
`ifdef WORD_SERIALIZER_LAST_EN
    check({tag, "_last"}, 64'(bus4.out_last), 64'(last));
`else
    if (last) begin
      check({tag, "_last_ready"}, 64'(bus4.in_ready), 64'(bus4.out_ready));
    end
`endif
  endtask

  logic [7:0] basic_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       bp_ready  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_word   [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
  logic       bp_inr    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] b2b_exp   [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] rst_exp   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in        = 32'h0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in        = 16'h0;
    bus1.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    #1;
    check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus4.in_ready),  64'd1);
    check("rst_out",       64'(bus4.out),       64'd0);
    check("rst1_out_valid", 64'(bus1.out_valid), 64'd0);
`ifdef WORD_SERIALIZER_LAST_EN
    check("rst_out_last", 64'(bus4.out_last), 64'd0);
`endif
    reset = 1'b0;
    tick();

    // Basic
    bus4.in = 32'h44332211;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    #1;
    check("basic_accept_ready", 64'(bus4.in_ready), 64'd1);
    tick();
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_word4($sformatf("basic%0d", k), basic_exp[k], (k == 3));
      tick();
    end
    #1;
    check("basic_done_valid", 64'(bus4.out_valid), 64'd0);
    check("basic_done_ready", 64'(bus4.in_ready),  64'd1);

    // Backpressure
    bus4.in = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus4.out_ready = bp_ready[k];
      #1;
      check($sformatf("bp%0d_valid", k), 64'(bus4.out_valid), 64'd1);
      check($sformatf("bp%0d_out", k),   64'(bus4.out),       64'(bp_word[k]));
      check($sformatf("bp%0d_inrdy", k), 64'(bus4.in_ready),  64'(bp_inr[k]));
      tick();
    end
    bus4.out_ready = 1'b1;
    #1;
    check("bp_done_valid", 64'(bus4.out_valid), 64'd0);

    // Back-to-back vectors, in_valid held high
    bus4.in = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in = 32'h88776655;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        bus4.in_valid = 1'b0;
      end
      #1;
      expect_word4($sformatf("b2b%0d", k), b2b_exp[k], (k == 3) || (k == 7));
      if (k == 3) begin
        check("b2b_accept_on_last", 64'(bus4.in_ready), 64'd1);
      end else if (k < 3) begin
        check($sformatf("b2b%0d_busy", k), 64'(bus4.in_ready), 64'd0);
      end else begin
        n_checks = n_checks;
      end
      tick();
    end
    #1;
    check("b2b_done_valid", 64'(bus4.out_valid), 64'd0);

    // Reset mid-vector (after 0x22 transfers), inputs offered during reset
    bus4.in = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    #1;
    expect_word4("rmv0", 8'h11, 1'b0);
    tick();
    #1;
    expect_word4("rmv1", 8'h22, 1'b0);
    tick();
    reset = 1'b1;
    bus4.in = 32'h99999999;
    bus4.in_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus4.in_valid = 1'b0;
    #1;
    check("rmv_after_valid", 64'(bus4.out_valid), 64'd0);
    check("rmv_after_ready", 64'(bus4.in_ready),  64'd1);
    check("rmv_after_out",   64'(bus4.out),       64'd0);
    bus4.in = 32'hDDCCBBAA;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_word4($sformatf("rmv_new%0d", k), rst_exp[k], (k == 3));
      tick();
    end

    // Ignored input while BUSY at idx=1
    bus4.in = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    #1;
    expect_word4("ign0", 8'h11, 1'b0);
    tick();
    bus4.out_ready = 1'b0;
    bus4.in = 32'hFFFFFFFF;
    bus4.in_valid = 1'b1;
    #1;
    check("ign_in_ready", 64'(bus4.in_ready), 64'd0);
    tick();
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      expect_word4($sformatf("ign%0d", k), basic_exp[k], (k == 3));
      tick();
    end
    #1;
    check("ign_done_valid", 64'(bus4.out_valid), 64'd0);

    // N=1 streaming
    bus1.in = 16'hAAAA;
    bus1.in_valid = 1'b1;
    bus1.out_ready = 1'b1;
    tick();
    bus1.in = 16'hBBBB;
    #1;
    check("n1_w0_valid", 64'(bus1.out_valid), 64'd1);
    check("n1_w0_out",   64'(bus1.out),       64'hAAAA);
    check("n1_w0_ready", 64'(bus1.in_ready),  64'd1);
`ifdef WORD_SERIALIZER_LAST_EN
    check("n1_w0_last",  64'(bus1.out_last),  64'd1);
`endif
    tick();
    bus1.in_valid = 1'b0;
    #1;
    check("n1_w1_valid", 64'(bus1.out_valid), 64'd1);
    check("n1_w1_out",   64'(bus1.out),       64'hBBBB);
`ifdef WORD_SERIALIZER_LAST_EN
    check("n1_w1_last",  64'(bus1.out_last),  64'd1);
`endif
    tick();
    #1;
    check("n1_done_valid", 64'(bus1.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial converter. Accepts an N-word vector in one handshake and emits its words one per transfer on a valid/ready output stream, element 0 first. It is the read-side counterpart of the shift/delay chain: the shift chain accumulates a word stream over time, and this block unrolls a packed vector back into a timed word stream. It sits between wide producers (packed results) and narrow consumers in generated pipelines.

## Interface
Parameters:
- WIDTH, 32, bits per word
- N, 4, words per vector; legal range N >= 1

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  producer offers a vector
- in_ready  output  1  block accepts a vector this cycle
- in  input  N*WIDTH  packed vector; word k = in[k*WIDTH +: WIDTH]
- out_valid  output  1  `out` holds a valid word
- out_ready  input  1  consumer accepts `out` this cycle
- out  output  WIDTH  current word
- out_last  output  1  current word is word N-1 (present only with WORD_SERIALIZER_LAST_EN)

## Operation
- Storage: N-word buffer `buf`, index `idx` (width $clog2(N), minimum 1 bit), state in {IDLE, BUSY}.
- A transfer occurs on a side when valid & ready are both high in the same cycle.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an input transfer, capture `in` into `buf`, set idx=0, and go to BUSY.
- BUSY:
  - out_valid=1, out=buf[idx].
  - On an output transfer with idx<N-1: idx increments.
  - On an output transfer with idx==N-1 (last word):
    - If in_valid is also high: capture `in`, set idx=0, and stay BUSY (back-to-back).
    - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (state==BUSY & idx==N-1 & out_ready). This is a combinational path from out_ready to in_ready and is permitted.
- `out` and `out_last` are driven from registers and the idx mux only. They never depend combinationally on `in`.
- out_valid never drops while BUSY unless the last word transfers (AXI-style stability). `out` is stable while out_valid & ~out_ready.
- in_valid is ignored whenever in_ready=0. No vector is dropped or overwritten.
- N==1: idx is constant 0 and every output transfer is the last word. The block acts as a one-entry buffer with full throughput.

## Timing
- Latency: a vector accepted at edge t presents word 0 on `out` in cycle t+1.
- Throughput: one word per cycle with out_ready held high. Back-to-back vectors incur no bubble, giving N words per N cycles.
- Reset values: state=IDLE, idx=0, buf=0, out_valid=0, out=0, in_ready=1 (combinational, follows state), out_last=0.
- Reset mid-vector: remaining words are discarded. out_valid=0 in the cycle after the reset edge. Inputs presented during reset are not captured.
- Reset has priority over any simultaneous transfer.

## Configuration
- WORD_SERIALIZER_LAST_EN
  - Defined: the out_last port exists and equals out_valid & (idx==N-1).
  - Undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package word_serializer_pkg holds the state typedef (enum logic {IDLE, BUSY}) and a function for the idx width (max(1, $clog2(N))).
- Sub-module wrap_counter holds the index register:
  - Parameter MAX.
  - Ports: clk, reset, clear, inc; output value.
  - Behaviour: wraps MAX-1 -> 0; clear has priority over inc.
- The FSM, buffer and handshake logic live in word_serializer.

## Test plan
- Basic: WIDTH=8, N=4, in=0x44332211, in_valid pulse, out_ready=1 -> out sequence 0x11, 0x22, 0x33, 0x44 on four consecutive cycles starting one cycle after acceptance; out_last high only with 0x44; then out_valid=0.
- Backpressure: same vector with out_ready toggling 1,0,0,1,1,0,1 -> each word held stable while stalled; exactly 4 transfers in order; in_ready=0 until the last transfer.
- Back-to-back: two vectors 0x44332211 then 0x88776655 with in_valid held high and out_ready=1 -> 8 contiguous words with no bubble; second vector accepted in the same cycle as the 0x44 transfer.
- N=1: WIDTH=16, vectors 0xAAAA then 0xBBBB streamed with out_ready=1 -> one word per cycle; out_last always high when out_valid=1.
- Reset mid-vector: assert reset after word 0x22 transfers -> next cycle out_valid=0, in_ready=1; a new vector 0xDDCCBBAA then yields 0xAA first.
- Ignored input: in_valid with in=0xFFFFFFFF while BUSY at idx=1 -> not captured; the original vector completes unchanged.
